hazard_flush_ctrl: RTL and testbench

//  Drives the FLUSH and BUSYWAIT inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC hold.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/div_stall_counter.sv | 65 ++++++
 rtl/hazard_flush_ctrl.sv | 77 +++++++
 tb/tb_hazard_flush_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / flush controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    DivIdle  = 2'd0,
    DivCount = 2'd1,
    DivDone  = 2'd2
  } div_state_e;

  localparam logic [4:0] RegZero = 5'd0;

endpackage

// File: rtl/div_stall_counter.sv
// Holds a DIV/REM instruction in EX for DivLatency cycles, counting the detect cycle,
// then parks in DivDone until the pipe is free to advance.
module div_stall_counter
  import hazard_pkg::*;
#(
  parameter int unsigned DivLatency = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       div_valid_i,
  input  logic       mem_busy_i,
  output logic       div_busy_o,
  output div_state_e state_o
);

  localparam int unsigned CntW = $clog2(DivLatency + 1);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DivIdle: begin
        if (div_valid_i) begin
          if (DivLatency == 1) begin
            state_d = DivDone;
          end else begin
            state_d = DivCount;
            cnt_d   = CntW'(DivLatency - 1);
          end
        end
      end
      DivCount: begin
        // Keeps counting through memory stalls; the divider runs regardless.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = DivDone;
        end
      end
      DivDone: begin
        // Valid still high here is the same instruction, so never restart from DivDone.
        if (!mem_busy_i) begin
          state_d = DivIdle;
        end
      end
      default: state_d = DivIdle;
    endcase
  end

  assign div_busy_o = ((state_q == DivIdle) && div_valid_i) || (state_q == DivCount);
  assign state_o    = state_q;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller: load-use stall, branch squash, memory/divider freeze.
// Sources every FLUSH/BUSYWAIT pin of the pipeline registers and the PC hold.
module hazard_flush_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DivLatency = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  input  logic       ex_div_valid_i,
  input  logic       branch_taken_i,
  input  logic       imem_busywait_i,
  input  logic       dmem_busywait_i,
  output logic       pc_hold_o,
  output logic       if_id_hold_o,
  output logic       if_id_flush_o,
  output logic       id_ex_flush_o,
  output logic       pipe_busywait_o,
  output logic       div_busy_o
);

  logic       div_busy;
  logic       mem_busy;
  logic       pipe_busy;
  logic       load_use;
  div_state_e unused_div_state;

  assign mem_busy  = imem_busywait_i | dmem_busywait_i;
  assign pipe_busy = mem_busy | div_busy;

  div_stall_counter #(
    .DivLatency(DivLatency)
  ) u_div_stall_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .div_valid_i(ex_div_valid_i),
    .mem_busy_i (mem_busy),
    .div_busy_o (div_busy),
    .state_o    (unused_div_state)
  );

  assign load_use = ex_memread_i && (ex_rd_i != RegZero) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    pc_hold_o       = 1'b0;
    if_id_hold_o    = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    pipe_busywait_o = 1'b0;
    div_busy_o      = 1'b0;
    if (!rst_i) begin
      pipe_busywait_o = pipe_busy;
      div_busy_o      = div_busy;
      // Flush would override busywait in the registers, so hold it back until unfrozen.
      if (pipe_busy) begin
        pc_hold_o    = 1'b1;
        if_id_hold_o = 1'b1;
      end else if (branch_taken_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (load_use) begin
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios plus a randomized run
// compared against a cycle-count based reference model.
module tb_hazard_flush_ctrl;

  localparam int unsigned Lat = 4;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_memread, ex_div_valid;
  logic       branch_taken, imem_bw, dmem_bw;
  logic       pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_bw, div_busy;
  logic [5:0] got;

  int checks   = 0;
  int failures = 0;

  hazard_flush_ctrl #(
    .DivLatency(Lat)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_uses_rs1_i  (id_uses_rs1),
    .id_uses_rs2_i  (id_uses_rs2),
    .ex_rd_i        (ex_rd),
    .ex_memread_i   (ex_memread),
    .ex_div_valid_i (ex_div_valid),
    .branch_taken_i (branch_taken),
    .imem_busywait_i(imem_bw),
    .dmem_busywait_i(dmem_bw),
    .pc_hold_o      (pc_hold),
    .if_id_hold_o   (if_id_hold),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .pipe_busywait_o(pipe_bw),
    .div_busy_o     (div_busy)
  );

  // {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_busywait, div_busy}
  assign got = {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_bw, div_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0; ex_div_valid = 1'b0;
    branch_taken = 1'b0; imem_bw = 1'b0; dmem_bw = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    dmem_bw = 1'b1; branch_taken = 1'b1; ex_div_valid = 1'b1;
    #2;
    if (got !== 6'b000000) begin
      failures++; $display("FAIL reset_forced_zero got=%b exp=%b", got, 6'b000000);
    end
    checks++;
    tick();
    clear_inputs();
    rst = 1'b0;
    #2;
    if (got !== 6'b000000) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", got, 6'b000000);
    end
    checks++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #2;
    if (got !== 6'b110100) begin
      failures++; $display("FAIL load_use_rs1 got=%b exp=%b", got, 6'b110100);
    end
    checks++;
    tick();
    ex_memread = 1'b0; ex_rd = 5'd0;  // the bubble now sits in EX
    #2;
    if (got !== 6'b000000) begin
      failures++; $display("FAIL load_use_one_bubble got=%b exp=%b", got, 6'b000000);
    end
    checks++;
    tick();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #2;
    if (got !== 6'b000000) begin
      failures++; $display("FAIL load_use_x0 got=%b exp=%b", got, 6'b000000);
    end
    checks++;
    tick();
    ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; id_uses_rs2 = 1'b0;
    #2;
    if (got !== 6'b000000) begin
      failures++; $display("FAIL load_use_rs2_unused got=%b exp=%b", got, 6'b000000);
    end
    checks++;
    id_uses_rs2 = 1'b1;
    #1;
    if (got !== 6'b110100) begin
      failures++; $display("FAIL load_use_rs2 got=%b exp=%b", got, 6'b110100);
    end
    checks++;
    tick();
  endtask

  task automatic test_branch_priority();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; branch_taken = 1'b1;
    #2;
    if (got !== 6'b001100) begin
      failures++; $display("FAIL branch_over_load_use got=%b exp=%b", got, 6'b001100);
    end
    checks++;
    tick();
  endtask

  task automatic test_div_latency();
    do_reset();
    ex_div_valid = 1'b1;
    for (int c = 0; c < int'(Lat); c++) begin
      #2;
      if (got !== 6'b110011) begin
        failures++; $display("FAIL div_freeze_cycle%0d got=%b exp=%b", c, got, 6'b110011);
      end
      checks++;
      tick();
    end
    #2;
    if (got !== 6'b000000) begin
      failures++; $display("FAIL div_done got=%b exp=%b", got, 6'b000000);
    end
    checks++;
    tick();
    // Back in IDLE, a second DIV is detected straight away.
    #2;
    if (got !== 6'b110011) begin
      failures++; $display("FAIL div_back_to_back got=%b exp=%b", got, 6'b110011);
    end
    checks++;
    tick();
  endtask

  task automatic test_branch_busywait();
    do_reset();
    branch_taken = 1'b1; dmem_bw = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      if (got !== 6'b110010) begin
        failures++; $display("FAIL branch_frozen_cycle%0d got=%b exp=%b", c, got, 6'b110010);
      end
      checks++;
      tick();
    end
    dmem_bw = 1'b0;
    #2;
    if (got !== 6'b001100) begin
      failures++; $display("FAIL branch_after_freeze got=%b exp=%b", got, 6'b001100);
    end
    checks++;
    tick();
  endtask

  task automatic test_div_dmem();
    logic [5:0] exp_seq [6];
    do_reset();
    ex_div_valid = 1'b1;
    tick();
    tick();  // COUNT with cnt=2
    dmem_bw = 1'b1;
    exp_seq[0] = 6'b110011;  // cnt=2
    exp_seq[1] = 6'b110011;  // cnt=1
    exp_seq[2] = 6'b110010;  // DONE, held by dmem
    exp_seq[3] = 6'b110010;  // still DONE, no restart
    exp_seq[4] = 6'b000000;  // DONE, busywait dropped
    exp_seq[5] = 6'b110011;  // IDLE, detects again
    for (int c = 0; c < 6; c++) begin
      if (c == 4) dmem_bw = 1'b0;
      #2;
      if (got !== exp_seq[c]) begin
        failures++; $display("FAIL div_dmem_step%0d got=%b exp=%b", c, got, exp_seq[c]);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    ex_div_valid = 1'b1;
    tick();
    tick();
    dmem_bw = 1'b1;
    rst = 1'b1;
    #1;
    if (got !== 6'b000000) begin
      failures++; $display("FAIL reset_async_mid_count got=%b exp=%b", got, 6'b000000);
    end
    checks++;
    tick();
    clear_inputs();
    rst = 1'b0;
    #2;
    if (got !== 6'b000000) begin
      failures++; $display("FAIL reset_no_residual got=%b exp=%b", got, 6'b000000);
    end
    checks++;
    tick();
    ex_div_valid = 1'b1;
    #2;
    if (got !== 6'b110011) begin
      failures++; $display("FAIL reset_then_idle_detect got=%b exp=%b", got, 6'b110011);
    end
    checks++;
    tick();
  endtask

  task automatic test_random();
    bit         active;
    int         start;
    bit         busy, in_done, pbw, load_use;
    logic [5:0] exp;
    do_reset();
    active = 1'b0;
    start  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_uses_rs1  = 1'($urandom_range(0, 1));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      ex_memread   = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      imem_bw      = ($urandom_range(0, 6) == 0);
      dmem_bw      = ($urandom_range(0, 6) == 0);
      ex_div_valid = ($urandom_range(0, 5) == 0);
      // Divider freeze covers the Lat cycles starting at detection.
      if (!active) busy = ex_div_valid;
      else         busy = (cyc - start) < int'(Lat);
      in_done  = active && ((cyc - start) >= int'(Lat));
      pbw      = imem_bw || dmem_bw || busy;
      load_use = ex_memread && (ex_rd != 0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (pbw)               exp = {4'b1100, 1'b1, busy};
      else if (branch_taken) exp = 6'b001100;
      else if (load_use)     exp = 6'b110100;
      else                   exp = 6'b000000;
      #2;
      if (got !== exp) begin
        failures++; $display("FAIL random_cycle%0d got=%b exp=%b", cyc, got, exp);
      end
      checks++;
      if (!active && ex_div_valid) begin
        active = 1'b1;
        start  = cyc;
      end else if (in_done && !pbw) begin
        active = 1'b0;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_div_latency();
    test_branch_busywait();
    test_div_dmem();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
